// File: rtl/inv_matvec_solver.sv
// Computes x = A_inv * b for a 3x3 signed fixed-point matrix with one shared MAC,
// one product per cycle, rounding half-up and saturating each element.
module inv_matvec_solver #(
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned W         = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2:0][2:0][W-1:0]     A_inv,
    input  logic [2:0][W-1:0]          b_vec,
    output logic [2:0][W-1:0]          x_out,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int unsigned AW = 2 * W + 2;
    localparam logic signed [AW-1:0] RoundC = {{(AW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] SatMax = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {StIdle, StMac} state_t;

    state_t                   state_q, state_d;
    logic [2:0][2:0][W-1:0]   a_q;
    logic [2:0][W-1:0]        b_q;
    logic [1:0]               row_q, row_d, col_q, col_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic [2:0][W-1:0]        xs_q, xs_d;
    logic                     ovf_run_q, ovf_run_d;
    logic [2:0][W-1:0]        x_out_d;
    logic                     overflow_d, done_d, capture;

    logic signed [2*W-1:0]    prod;
    logic signed [AW-1:0]     sum, rounded;
    logic                     clip_hi, clip_lo;
    logic [W-1:0]             sat;

    assign prod    = $signed(a_q[row_q][col_q]) * $signed(b_q[col_q]);
    assign sum     = acc_q + {{2{prod[2*W-1]}}, prod};
    assign rounded = (sum + RoundC) >>> FRAC_BITS;
    assign clip_hi = rounded > SatMax;
    assign clip_lo = rounded < SatMin;
    assign sat     = clip_hi ? {1'b0, {(W-1){1'b1}}} :
                     clip_lo ? {1'b1, {(W-1){1'b0}}} : rounded[W-1:0];

    assign busy = (state_q == StMac);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        acc_d      = acc_q;
        xs_d       = xs_q;
        ovf_run_d  = ovf_run_q;
        x_out_d    = x_out;
        overflow_d = overflow;
        done_d     = 1'b0;
        capture    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture   = 1'b1;
                    acc_d     = '0;
                    row_d     = 2'd0;
                    col_d     = 2'd0;
                    ovf_run_d = 1'b0;
                    state_d   = StMac;
                end
            end
            StMac: begin
                if (col_q == 2'd2) begin
                    xs_d[row_q] = sat;
                    ovf_run_d   = ovf_run_q | clip_hi | clip_lo;
                    acc_d       = '0;
                    col_d       = 2'd0;
                    row_d       = row_q + 2'd1;
                    if (row_q == 2'd2) begin
                        // Publish the whole vector at once so x_out never shows a partial run.
                        row_d      = 2'd0;
                        state_d    = StIdle;
                        done_d     = 1'b1;
                        x_out_d    = xs_d;
                        overflow_d = ovf_run_d;
                    end
                end else begin
                    acc_d = sum;
                    col_d = col_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            acc_q     <= '0;
            xs_q      <= '0;
            ovf_run_q <= 1'b0;
            x_out     <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            acc_q     <= acc_d;
            xs_q      <= xs_d;
            ovf_run_q <= ovf_run_d;
            x_out     <= x_out_d;
            overflow  <= overflow_d;
            done      <= done_d;
            if (capture) begin
                a_q <= A_inv;
                b_q <= b_vec;
            end
        end
    end

endmodule

// File: tb/tb_inv_matvec_solver.sv
// Randomised and directed bench for inv_matvec_solver against a plain-arithmetic
// reference of x = A_inv * b with half-up rounding and saturation.
module tb_inv_matvec_solver;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [2:0][2:0][31:0]  a_inv;
    logic [2:0][31:0]       b_vec;
    logic [2:0][31:0]       x_out;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0][31:0] last_x;
    logic [2:0][31:0] exp_x;
    logic             exp_ovf;

    inv_matvec_solver #(.FRAC_BITS(16), .W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A_inv    (a_inv),
        .b_vec    (b_vec),
        .x_out    (x_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact signed dot products in wide integers, then round and clip.
    function automatic void model(input logic [2:0][2:0][31:0] m, input logic [2:0][31:0] v,
                                  output logic [2:0][31:0] x, output logic ovf);
        logic signed [127:0] s, p, q, r;
        logic signed [127:0] hi, lo;
        hi  = 128'sd2147483647;
        lo  = -128'sd2147483648;
        ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = 0;
            for (int j = 0; j < 3; j++) begin
                p = $signed(m[i][j]);
                q = $signed(v[j]);
                s = s + p * q;
            end
            r = (s + 128'sd32768) >>> 16;
            if (r > hi) begin
                x[i] = 32'h7FFFFFFF;
                ovf  = 1'b1;
            end else if (r < lo) begin
                x[i] = 32'h80000000;
                ovf  = 1'b1;
            end else begin
                x[i] = r[31:0];
            end
        end
    endfunction

    function automatic logic [31:0] rnd();
        logic signed [31:0] v;
        v = $urandom();
        return v >>> $urandom_range(0, 24);
    endfunction

    task automatic start_run(input logic [2:0][2:0][31:0] m, input logic [2:0][31:0] v);
        a_inv = m;
        b_vec = v;
        start = 1'b1;
        model(m, v, exp_x, exp_ovf);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered one cycle after the start edge; leaves in the done cycle.
    task automatic wait_done(input string tag);
        int busy_cnt = 0;
        int cyc;
        bit held = 1'b1;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (done) break;
            if (busy) busy_cnt++;
            if (x_out !== last_x) held = 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, "_latency"}, cyc, 10);
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_x_held"}, held, 1);
        check({tag, "_x"}, x_out, exp_x);
        check({tag, "_ovf"}, overflow, exp_ovf);
        last_x = exp_x;
    endtask

    task automatic do_run(input string tag, input logic [2:0][2:0][31:0] m,
                          input logic [2:0][31:0] v);
        start_run(m, v);
        wait_done(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [2:0][2:0][31:0] m, m2;
        logic [2:0][31:0]      v, v2, saved_x;
        int                    ndone, dcyc;

        rst_n  = 1'b0;
        start  = 1'b0;
        a_inv  = '0;
        b_vec  = '0;
        last_x = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_x", x_out, 0);
        check("reset_flags", {busy, done, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = (i == j) ? 32'h00010000 : 32'h0;
        v = {32'hFFFD0000, 32'h00020000, 32'h00010000};
        do_run("identity", m, v);

        // Rounding of +0.5 and -0.5 LSB
        m = '0;
        m[0][0] = 32'h00008000;
        v = {32'h0, 32'h0, 32'h00000001};
        do_run("round_pos", m, v);
        v = {32'h0, 32'h0, 32'hFFFFFFFF};
        do_run("round_neg", m, v);

        // Saturation both ways
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = 32'h7FFFFFFF;
        v = {3{32'h7FFFFFFF}};
        do_run("sat_pos", m, v);
        v = {3{32'h80000000}};
        do_run("sat_neg", m, v);

        // Start while busy, and matrix changed mid-run
        for (int i = 0; i < 3; i++) begin
            v[i] = rnd();
            for (int j = 0; j < 3; j++) m[i][j] = rnd();
        end
        start_run(m, v);
        ndone = 0;
        dcyc  = 0;
        saved_x = '0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (done) begin
                ndone++;
                dcyc    = cyc;
                saved_x = x_out;
            end
            if (cyc == 2)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) a_inv[i][j] = rnd();
            start = (cyc == 4);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        check("busy_start_cycle", dcyc, 10);
        check("busy_start_x", saved_x, exp_x);
        check("busy_start_ovf", overflow, exp_ovf);
        last_x = exp_x;

        // Back-to-back: second start in the done cycle of the first run
        for (int i = 0; i < 3; i++) begin
            v[i]  = rnd();
            v2[i] = rnd();
            for (int j = 0; j < 3; j++) begin
                m[i][j]  = rnd();
                m2[i][j] = rnd();
            end
        end
        start_run(m, v);
        wait_done("b2b_first");
        start_run(m2, v2);
        wait_done("b2b_second");
        @(posedge clk);
        #1;

        // Randomised runs
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = rnd();
                for (int j = 0; j < 3; j++) m[i][j] = rnd();
            end
            do_run($sformatf("rand%0d", k), m, v);
        end

        // Asynchronous reset mid-run after a saturating result is on the outputs
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[i][j] = 32'h7FFFFFFF;
        v = {3{32'h7FFFFFFF}};
        do_run("pre_reset", m, v);
        for (int i = 0; i < 3; i++) begin
            v[i] = rnd();
            for (int j = 0; j < 3; j++) m[i][j] = rnd();
        end
        start_run(m, v);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_x", x_out, 0);
        check("rst_flags", {busy, done, overflow}, 0);
        last_x = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_no_done", ndone, 0);
        for (int i = 0; i < 3; i++) begin
            v[i] = rnd();
            for (int j = 0; j < 3; j++) m[i][j] = rnd();
        end
        do_run("post_reset", m, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
